// File: rtl/adxl355_spi_reader_if.sv
// Signal bundle between adxl355_spi_reader and its neighbours: drdy request, SPI bus, samples.
// ADXL355_OVERRUN_CNT_EN adds the o_overrun counter to the bundle.
interface adxl355_spi_reader_if;
  logic               i_clk_drdy;
  logic               o_csn;
  logic               o_sclk;
  logic               o_mosi;
  logic               i_miso;
  logic signed [19:0] o_x;
  logic signed [19:0] o_y;
  logic signed [19:0] o_z;
  // o_valid is a one-cycle strobe with no ready: the consumer must take every sample,
  // and o_x/o_y/o_z stay stable until the next strobe.
  logic               o_valid;
  logic               o_busy;
  logic [2:0]         o_dbg_state;
`ifdef ADXL355_OVERRUN_CNT_EN
  logic [15:0]        o_overrun;

  modport master (
    input  i_clk_drdy, i_miso,
    output o_csn, o_sclk, o_mosi, o_x, o_y, o_z, o_valid, o_busy, o_dbg_state, o_overrun
  );
  modport slave (
    output i_clk_drdy, i_miso,
    input  o_csn, o_sclk, o_mosi, o_x, o_y, o_z, o_valid, o_busy, o_dbg_state, o_overrun
  );
`else
  modport master (
    input  i_clk_drdy, i_miso,
    output o_csn, o_sclk, o_mosi, o_x, o_y, o_z, o_valid, o_busy, o_dbg_state
  );
  modport slave (
    output i_clk_drdy, i_miso,
    input  o_csn, o_sclk, o_mosi, o_x, o_y, o_z, o_valid, o_busy, o_dbg_state
  );
`endif
endinterface

// File: rtl/adxl355_spi_reader.sv
// SPI mode-0 burst reader for ADXL355 XDATA3..ZDATA1, one burst per drdy pulse.
// Optional ADXL355_OVERRUN_CNT_EN adds a saturating count of drdy pulses seen while busy.
module adxl355_spi_reader #(
  parameter int         clk_half_div = 4,
  parameter logic [7:0] first_reg    = 8'h08,
  parameter int         cs_setup     = 4,
  parameter int         cs_hold      = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  adxl355_spi_reader_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int PH_W     = $clog2(clk_half_div) + 1;
  localparam int WAIT_MAX = (cs_setup > cs_hold) ? cs_setup : cs_hold;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(clk_half_div - 1);
  localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(cs_setup - 1);
  localparam logic [WAIT_W-1:0] HOLD_LAST  = WAIT_W'(cs_hold - 1);
  localparam logic [6:0]        BIT_LAST   = 7'd79;
  localparam logic [6:0]        CMD_BITS   = 7'd8;
  localparam logic [7:0]        CMD_BYTE   = {first_reg[6:0], 1'b1};

  state_e            state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [6:0]        bit_q, bit_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              sclk_q, sclk_d;
  logic [7:0]        tx_q, tx_d;
  logic [71:0]       rx_q, rx_d;
  logic [19:0]       x_q, x_d;
  logic [19:0]       y_q, y_d;
  logic [19:0]       z_q, z_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      wait_q  <= '0;
      sclk_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      wait_q  <= wait_d;
      sclk_q  <= sclk_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    wait_d  = wait_q;
    sclk_d  = sclk_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_clk_drdy) begin
          state_d = ST_SETUP;
          tx_d    = CMD_BYTE;
          rx_d    = '0;
          bit_d   = '0;
          ph_d    = '0;
          wait_d  = '0;
        end
      end

      ST_SETUP: begin
        if (wait_q == SETUP_LAST) begin
          state_d = ST_SHIFT;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (!sclk_q) begin
            // Rising edge: sensor data is stable, capture it; command-phase bits are dropped.
            sclk_d = 1'b1;
            if (bit_q >= CMD_BITS) begin
              rx_d = {rx_q[70:0], bus.i_miso};
            end
          end else begin
            // Falling edge opens the next bit's low phase, so MOSI advances here.
            sclk_d = 1'b0;
            tx_d   = {tx_q[6:0], 1'b0};
            if (bit_q == BIT_LAST) begin
              state_d = ST_HOLD;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      ST_HOLD: begin
        if (wait_q == HOLD_LAST) begin
          state_d = ST_DONE;
          wait_d  = '0;
          // Each axis is the top 20 bits of its 3-byte group; the low nibble is reserved.
          x_d     = rx_q[71:52];
          y_d     = rx_q[47:28];
          z_d     = rx_q[23:4];
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  logic unused_nibbles;
  assign unused_nibbles = ^{rx_q[51:48], rx_q[27:24], rx_q[3:0], first_reg[7]};

`ifdef ADXL355_OVERRUN_CNT_EN
  logic [15:0] ovr_q, ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (bus.i_clk_drdy && (state_q != ST_IDLE) && (ovr_q != 16'hFFFF)) begin
      ovr_d = ovr_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign bus.o_overrun = ovr_q;
`endif

  assign bus.o_csn       = !((state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD));
  assign bus.o_sclk      = sclk_q;
  assign bus.o_mosi      = tx_q[7];
  assign bus.o_x         = $signed(x_q);
  assign bus.o_y         = $signed(y_q);
  assign bus.o_z         = $signed(z_q);
  assign bus.o_valid     = (state_q == ST_DONE);
  assign bus.o_busy      = (state_q != ST_IDLE);
  assign bus.o_dbg_state = state_q;

endmodule
